// File: rtl/bus_ctrl.sv
// Peripheral bus initiator: one CPU load/store at a time, region decode,
// per-region wait states, read capture and a one-cycle ack with error flag.
module bus_ctrl #(
    parameter logic [3:0] WAIT_RAM = 4'd1,
    parameter logic [3:0] WAIT_IO  = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [4:0]  bSel,
    output logic [31:0] bAddr,
    output logic [31:0] bWData,
    output logic        bWr,
    output logic        bRd,
    input  logic [31:0] bData
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  dec_sel;
    logic        dec_ok;

    // GPIO in is read-only, so a write there is rejected like a miss
    always_comb begin
        dec_sel = 5'b00000;
        case (cpu_addr[15:12])
            4'h0:    dec_sel = 5'b00001;
            4'h1:    dec_sel = 5'b00010;
            4'h2:    dec_sel = 5'b00100;
            4'h3:    dec_sel = 5'b01000;
            default: dec_sel = 5'b00000;
        endcase
        if (cpu_addr[31:16] != 16'h0000) begin
            dec_sel = 5'b00000;
        end
        dec_ok = (dec_sel != 5'b00000) && !(cpu_we && dec_sel[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 12'h000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            sel_q   <= 5'b00000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr[11:0];
                    wdata_d = cpu_wdata;
                    sel_d   = dec_ok ? dec_sel : 5'b00000;
                    err_d   = !dec_ok;
                    cnt_d   = dec_sel[0] ? WAIT_RAM : WAIT_IO;
                    state_d = dec_ok ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = bData;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bSel      = 5'b00000;
        bRd       = 1'b0;
        bWr       = 1'b0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        bAddr     = {20'h00000, addr_q};
        bWData    = wdata_q;
        cpu_rdata = rdata_q;
        case (state_q)
            ACCESS: begin
                bSel = sel_q;
                bRd  = !we_q;
                bWr  = we_q && (cnt_q == 4'd0);
            end
            DONE: begin
                cpu_ack = 1'b1;
                cpu_err = err_q;
            end
            default: begin
                bSel = 5'b00000;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Bench for bus_ctrl: directed vector table, reset and back-to-back
// sequences, then random transactions against a region-rule model.
module tb_bus_ctrl;

    localparam int W_RAM = 1;
    localparam int W_IO  = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [4:0]  bSel;
    logic [31:0] bAddr;
    logic [31:0] bWData;
    logic        bWr;
    logic        bRd;
    logic [31:0] bData;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = 32'h0;

    bus_ctrl #(.WAIT_RAM(4'd1), .WAIT_IO(4'd0)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata),
        .bSel(bSel), .bAddr(bAddr), .bWData(bWData),
        .bWr(bWr), .bRd(bRd), .bData(bData)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bd;
        logic        exp_err;
        logic [4:0]  exp_sel;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outs(input string nm);
        chk({nm, "_ctl"}, {25'h0, cpu_ack, cpu_err, bSel}, 32'h0);
        chk({nm, "_rw"}, {30'h0, bWr, bRd}, 32'h0);
        chk({nm, "_addr"}, bAddr, 32'h0);
        chk({nm, "_wdata"}, bWData, 32'h0);
        chk({nm, "_rdata"}, cpu_rdata, 32'h0);
    endtask

    // Issue one request from IDLE and watch the bus until the ack
    task automatic do_txn(input vec_t v);
        int lat, sel_cyc, rd_cyc, wr_cyc, wr_at;
        int bad_sel, bad_addr, bad_wd;
        logic err_s;
        logic [31:0] rd_s;
        lat = 0; sel_cyc = 0; rd_cyc = 0; wr_cyc = 0; wr_at = 0;
        bad_sel = 0; bad_addr = 0; bad_wd = 0;
        err_s = 1'b0; rd_s = 32'h0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
        cpu_wdata = v.wdata; bData = v.bd;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = ~v.we;
        cpu_addr = $urandom; cpu_wdata = $urandom;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (bSel != 5'b0) begin
                sel_cyc++;
                if (bSel != v.exp_sel) bad_sel++;
                if (bAddr != {20'h0, v.addr[11:0]}) bad_addr++;
                if (v.we && bWData != v.wdata) bad_wd++;
            end
            if (bRd) rd_cyc++;
            if (bWr) begin wr_cyc++; wr_at = c; end
            if (cpu_ack) begin
                lat = c; err_s = cpu_err; rd_s = cpu_rdata;
            end
            if (lat == 0) begin @(posedge clk); #1; end
        end
        chk({v.nm, "_lat"}, lat, v.exp_lat);
        chk({v.nm, "_err"}, {31'h0, err_s}, {31'h0, v.exp_err});
        chk({v.nm, "_rdata"}, rd_s, v.exp_rd);
        chk({v.nm, "_selcyc"}, sel_cyc,
            (v.exp_sel != 0) ? v.exp_lat - 1 : 0);
        chk({v.nm, "_rdcyc"}, rd_cyc,
            (v.exp_sel != 0 && !v.we) ? v.exp_lat - 1 : 0);
        chk({v.nm, "_wrcyc"}, wr_cyc, (v.exp_sel != 0 && v.we) ? 1 : 0);
        if (v.exp_sel != 0 && v.we)
            chk({v.nm, "_wrpos"}, wr_at, v.exp_lat - 1);
        chk({v.nm, "_bad"}, bad_sel + bad_addr + bad_wd, 0);
        @(posedge clk); #1;
    endtask

    // Reset asserted during the first ACCESS cycle of a RAM access
    task automatic rst_mid(input logic we, input string nm);
        int acks, wrs;
        acks = 0; wrs = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = 32'h0000_0010;
        cpu_wdata = 32'h0BAD_0BAD; bData = 32'h7777_7777;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        chk({nm, "_pre_sel"}, {27'h0, bSel}, 32'h1);
        @(negedge clk); rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk_idle_outs(nm);
        end
        @(negedge clk); rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu_ack) acks++;
            if (bWr) wrs++;
        end
        chk({nm, "_post_ack"}, acks, 0);
        chk({nm, "_post_wr"}, wrs, 0);
        model_rdata = 32'h0;
    endtask

    function automatic vec_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wd,
                                   input logic [31:0] bd);
        vec_t v;
        int region;
        bit legal;
        region = int'(addr[15:12]);
        legal = (addr[31:16] == 16'h0) && region < 4 &&
                !(we && region == 1);
        v.nm = "rand"; v.we = we; v.addr = addr;
        v.wdata = wd; v.bd = bd;
        v.exp_err = !legal;
        v.exp_sel = legal ? 5'(1 << region) : 5'b0;
        v.exp_lat = legal ? ((region == 0 ? W_RAM : W_IO) + 2) : 1;
        if (legal && !we) model_rdata = bd;
        v.exp_rd = model_rdata;
        return v;
    endfunction

    initial begin
        vec_t tbl[10];
        logic [4:0] b2b_sel[7];
        int b2b_ack[7];
        int b2b_wr[7];
        int b2b_rd[7];
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; bData = 32'h0;

        tbl[0] = '{"rd_gpio_in", 1'b0, 32'h0000_1004, 32'h0,
                   32'hDEAD_BEEF, 1'b0, 5'b00010, 2, 32'hDEAD_BEEF};
        tbl[1] = '{"wr_ram", 1'b1, 32'h0000_0010, 32'h1234_5678,
                   32'h5555_5555, 1'b0, 5'b00001, 3, 32'hDEAD_BEEF};
        tbl[2] = '{"wr_gpio_in", 1'b1, 32'h0000_1000, 32'hFFFF_0000,
                   32'h6666_6666, 1'b1, 5'b00000, 1, 32'hDEAD_BEEF};
        tbl[3] = '{"rd_unmap5", 1'b0, 32'h0000_5000, 32'h0,
                   32'h1111_1111, 1'b1, 5'b00000, 1, 32'hDEAD_BEEF};
        tbl[4] = '{"rd_hi", 1'b0, 32'h0001_0000, 32'h0,
                   32'h2222_2222, 1'b1, 5'b00000, 1, 32'hDEAD_BEEF};
        tbl[5] = '{"rd_pwm", 1'b0, 32'h0000_3008, 32'h0,
                   32'hCAFE_F00D, 1'b0, 5'b01000, 2, 32'hCAFE_F00D};
        tbl[6] = '{"wr_gpio_out", 1'b1, 32'h0000_2FFC, 32'h8765_4321,
                   32'h3333_3333, 1'b0, 5'b00100, 2, 32'hCAFE_F00D};
        tbl[7] = '{"rd_ram_top", 1'b0, 32'h0000_0FFF, 32'h0,
                   32'hA5A5_A5A5, 1'b0, 5'b00001, 3, 32'hA5A5_A5A5};
        tbl[8] = '{"rd_unmap4", 1'b0, 32'h0000_4000, 32'h0,
                   32'h4444_4444, 1'b1, 5'b00000, 1, 32'hA5A5_A5A5};
        tbl[9] = '{"wr_hi_bit", 1'b1, 32'h8000_3000, 32'h1,
                   32'h0, 1'b1, 5'b00000, 1, 32'hA5A5_A5A5};

        b2b_sel = '{5'b01000, 5'b0, 5'b0, 5'b00100, 5'b0, 5'b0, 5'b0};
        b2b_ack = '{0, 1, 0, 0, 1, 0, 0};
        b2b_wr  = '{1, 0, 0, 0, 0, 0, 0};
        b2b_rd  = '{0, 0, 0, 1, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk_idle_outs("reset");
        @(negedge clk); rst = 1'b0;

        rst_mid(1'b0, "rst_rd");
        rst_mid(1'b1, "rst_wr");

        for (int i = 0; i < 10; i++) do_txn(tbl[i]);

        // Request held high across a PWM write then a GPIO out read
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_3000;
        cpu_wdata = 32'h0000_00FF; bData = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 32'h0000_2000;
        for (int c = 1; c <= 7; c++) begin
            if (c == 4) cpu_req = 1'b0;
            chk($sformatf("b2b_sel_%0d", c), {27'h0, bSel},
                {27'h0, b2b_sel[c-1]});
            chk($sformatf("b2b_ack_%0d", c), {31'h0, cpu_ack},
                b2b_ack[c-1]);
            chk($sformatf("b2b_wr_%0d", c), {31'h0, bWr}, b2b_wr[c-1]);
            chk($sformatf("b2b_rd_%0d", c), {31'h0, bRd}, b2b_rd[c-1]);
            if (c == 1) chk("b2b_wdata", bWData, 32'h0000_00FF);
            if (c == 5) chk("b2b_rdata", cpu_rdata, 32'h0F0F_0F0F);
            if (b2b_ack[c-1] == 1) chk("b2b_err", {31'h0, cpu_err}, 0);
            @(posedge clk); #1;
        end
        model_rdata = 32'h0F0F_0F0F;

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            vec_t v;
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = {16'h0, 1'b0, 3'($urandom_range(0, 5)), a[11:0]};
            v = model(1'($urandom_range(0, 1)), a, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_txn(v);
        end

        rst_mid(1'b0, "rst_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Bus initiator for the SoC peripheral bus: accepts one CPU load/store at a time, decodes the address into the one-hot slave select, and drives the write strobe and write data toward RAM, GPIO and PWM. It counts per-region wait states, captures the read data returned through the read-data multiplexer, and returns a one-cycle acknowledge with an error flag. It is the requesting end of the bus whose return path is the slave read mux.

## Interface
- WAIT_RAM, 1: extra wait cycles for RAM accesses (0–15)
- WAIT_IO, 0: extra wait cycles for GPIO/PWM accesses (0–15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  request; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_ack; 1 = access rejected
- cpu_rdata  out  32  read data, valid with cpu_ack on reads; held until next read completes
- bSel  out  5  one-hot slave select: 00001 RAM, 00010 GPIO in, 00100 GPIO out, 01000 PWM, 00000 none
- bAddr  out  32  latched address, offset within region (cpu_addr[11:0], upper bits 0)
- bWData  out  32  latched write data
- bWr  out  1  single-cycle write strobe
- bRd  out  1  read enable, high throughout the access phase
- bData  in  32  read data returned from the slave mux

## Operation
- Address decode on cpu_addr[15:12]: 0x0 RAM, 0x1 GPIO in, 0x2 GPIO out, 0x3 PWM; every other value unmapped. cpu_addr[31:16] must be 0, otherwise unmapped.
- Illegal: unmapped address, or write to GPIO in (read-only). Illegal accesses never assert bSel, bWr or bRd.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: bSel=0, bRd=0, bWr=0. On cpu_req=1, latch we, address, wdata, decoded select; load wait counter with WAIT_RAM (RAM) or WAIT_IO (others). Legal → ACCESS; illegal → DONE with err=1.
- ACCESS: bSel, bAddr, bWData driven from latches; bRd=1 for reads every ACCESS cycle. Counter decrements each cycle; when counter==0 this is the last cycle: writes assert bWr for this cycle only, reads capture bData into cpu_rdata at the closing edge; → DONE.
- DONE: cpu_ack=1, cpu_err per latched status, bSel/bRd/bWr=0; → IDLE unconditionally.
- cpu_req during ACCESS/DONE ignored; a request still high in IDLE after DONE starts a new transaction (back-to-back allowed, one IDLE cycle between).
- cpu_rdata unchanged on writes and on errored reads.

## Timing
- Reset: state IDLE, all outputs 0 (cpu_ack, cpu_err, cpu_rdata, bSel, bAddr, bWData, bWr, bRd), counter 0.
- Legal access, req sampled at edge N: ACCESS cycles N+1..N+1+W (W = wait count), ack high in cycle N+2+W. WAIT_IO=0 read: ack 2 cycles after req edge; WAIT_RAM=1: 3 cycles.
- Illegal access: ack (err=1) in cycle N+1, no bus activity.
- bWr high exactly one cycle per write, coincident with last ACCESS cycle; bSel stable over all ACCESS cycles.
- Reset asserted mid-ACCESS or in DONE: next cycle IDLE, no ack, no bWr generated at or after the reset edge.
- Minimum spacing between acks: W+3 cycles.

## Test plan
- Reset: hold rst 2 cycles during an active RAM read → all outputs 0 next cycle, no ack afterwards.
- Read GPIO in, addr 0x0000_1004, WAIT_IO=0, bData=0xDEAD_BEEF → bSel=00010, bRd for 1 cycle, bAddr=0x004, ack 2 cycles after req, rdata=0xDEAD_BEEF, err=0.
- Write RAM, addr 0x0000_0010, wdata 0x1234_5678, WAIT_RAM=1 → bSel=00001 for 2 cycles, bWr high only in second, bWData=0x1234_5678, ack 3 cycles after req, err=0.
- Write GPIO in, addr 0x0000_1000 → no bSel/bWr, ack next cycle with err=1, rdata unchanged.
- Read 0x0000_5000 and 0x0001_0000 → ack with err=1, bSel stays 0, rdata unchanged.
- Back-to-back: req held high for PWM write 0x0000_3000 then GPIO out read 0x0000_2000 → two acks, bSel 01000 then 00100, req ignored while busy, exactly one bWr.
